// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Bundle between the register-file read side / pipeline control and the
// multi-cycle multiply/divide execute unit.
//
// Request side (driven by master):
//   start      - request, only looked at while the unit is idle
//   op_div     - 0 = multiply, 1 = divide
//   dest_addr  - destination register of the primary result
//   op1_data   - multiplicand / dividend
//   op2_data   - multiplier / divisor
// Result side (driven by slave):
//   busy, stall, done, reg_we, w_addr, w_data, reg14_we, w_reg14, div_by_zero
//
// Handshake: a request is accepted on a rising clock edge where start = 1
// and busy = 0; stall is high in that same cycle (combinationally) and for
// the whole operation, so the front end must hold while stall = 1. There is
// no backpressure on the result side: done/reg_we/reg14_we pulse for one
// cycle and the consumer must take the write in that cycle.
// ---------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_div;
    logic [3:0]       dest_addr;
    logic [WIDTH-1:0] op1_data;
    logic [WIDTH-1:0] op2_data;

    logic             busy;
    logic             stall;
    logic             done;
    logic             reg_we;
    logic [3:0]       w_addr;
    logic [WIDTH-1:0] w_data;
    logic             reg14_we;
    logic [WIDTH-1:0] w_reg14;
    logic             div_by_zero;

    modport master (
        output start, op_div, dest_addr, op1_data, op2_data,
        input  busy, stall, done, reg_we, w_addr, w_data,
               reg14_we, w_reg14, div_by_zero
    );

    modport slave (
        input  start, op_div, dest_addr, op1_data, op2_data,
        output busy, stall, done, reg_we, w_addr, w_data,
               reg14_we, w_reg14, div_by_zero
    );
endinterface

// File: rtl/muldiv_exec.sv
// ---------------------------------------------------------------------------
// muldiv_exec
// Multi-cycle execute unit placed after the register file. Performs an
// unsigned WIDTH x WIDTH shift-add multiply or an unsigned WIDTH / WIDTH
// restoring divide, one iteration per clock, and writes the results back
// through the register-file write ports.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous, active-high reset (aborts any operation)
//   bus          - muldiv_if.slave: request (start/op_div/dest_addr/op1/op2)
//                  and result (busy/stall/done/reg_we/w_addr/w_data/
//                  reg14_we/w_reg14/div_by_zero)
//   o_state      - current FSM state, for observation
//
// Result mapping: multiply -> w_data = product low, w_reg14 = product high;
// divide -> w_data = quotient, w_reg14 = remainder; divide by zero ->
// w_data = all ones, w_reg14 = dividend, div_by_zero = 1.
// ---------------------------------------------------------------------------
module muldiv_exec #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] REG14 = 4'd14;

    state_t             r_state;
    state_t             w_next_state;

    logic               w_accept;
    logic               w_busy;
    logic               w_op2_zero;

    // Iteration datapath. For both operations the pair {r_hi, r_lo} is the
    // 2*WIDTH accumulator and r_op is the fixed operand (multiplicand or
    // divisor). Multiply starts with r_lo = multiplier, divide with
    // r_lo = dividend; in both cases the final low half lands in r_lo and
    // the high half / remainder in r_hi, so the write-back mapping is shared.
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_op;
    logic [3:0]         r_dest;
    logic               r_dbz_pend;
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_div_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    // Registered write-back outputs.
    logic               r_done;
    logic               r_reg_we;
    logic               r_reg14_we;
    logic [3:0]         r_w_addr;
    logic [WIDTH-1:0]   r_w_data;
    logic [WIDTH-1:0]   r_w_reg14;
    logic               r_dbz;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    assign w_op2_zero = (bus.op2_data == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    // Divide by zero skips the iterations entirely.
                    w_next_state = (bus.op_div && w_op2_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy   = (r_state == S_RUN) || (r_state == S_DONE);
        w_accept = (r_state == S_IDLE) && bus.start;
    end

    assign bus.busy  = w_busy;
    // Combinational so the front end holds in the very cycle a request is taken.
    assign bus.stall = w_busy || w_accept;
    assign o_state   = r_state;

    // ------------------------------------------------------------------
    // One multiply step: conditionally add the multiplicand to the high
    // half, then shift the whole accumulator right by one (the carry-out
    // of the add becomes the new top bit).
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // One restoring-divide step: shift the partial remainder left, pulling
    // in the next dividend bit, and subtract the divisor when it fits. The
    // shifted remainder needs WIDTH+1 bits for the compare, but whenever the
    // subtraction is taken the result is below the divisor, so a WIDTH-bit
    // difference is exact.
    // ------------------------------------------------------------------
    always_comb begin
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_div_ge  = (w_rem_sh >= {1'b0, r_op});
        w_div_sub = w_rem_sh[WIDTH-1:0] - r_op;
        w_div_hi  = w_div_ge ? w_div_sub : w_rem_sh[WIDTH-1:0];
        w_div_lo  = {r_lo[WIDTH-2:0], w_div_ge};
    end

    // ------------------------------------------------------------------
    // Operand capture and iteration
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_dbz_pend <= 1'b0;
            r_is_div   <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= bus.op_div ? bus.op1_data : bus.op2_data;
            r_op       <= bus.op_div ? bus.op2_data : bus.op1_data;
            r_dest     <= bus.dest_addr;
            r_dbz_pend <= bus.op_div && w_op2_zero;
            r_is_div   <= bus.op_div;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end else begin
                r_hi <= w_mul_hi;
                r_lo <= w_mul_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back registers. The write pulses are launched from DONE and
    // last one cycle; address/data hold until the next completion.
    // div_by_zero stays up until the next request is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg14_we <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_w_reg14  <= '0;
            r_dbz      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg14_we <= 1'b0;
            if (w_accept) begin
                r_dbz <= 1'b0;
            end
            if (r_state == S_DONE) begin
                r_done     <= 1'b1;
                // Register 14 already receives the high half / remainder,
                // so a primary write to it is suppressed.
                r_reg_we   <= (r_dest != REG14);
                r_reg14_we <= 1'b1;
                r_w_addr   <= r_dest;
                if (r_dbz_pend) begin
                    r_w_data  <= '1;
                    r_w_reg14 <= r_lo;  // untouched dividend
                    r_dbz     <= 1'b1;
                end else begin
                    r_w_data  <= r_lo;
                    r_w_reg14 <= r_hi;
                end
            end
        end
    end

    assign bus.done        = r_done;
    assign bus.reg_we      = r_reg_we;
    assign bus.reg14_we    = r_reg14_we;
    assign bus.w_addr      = r_w_addr;
    assign bus.w_data      = r_w_data;
    assign bus.w_reg14     = r_w_reg14;
    assign bus.div_by_zero = r_dbz;

endmodule
